// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM encoding and default constants for the UART transmit arbiter
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  localparam int BUSY_TIMEOUT_DEF = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin pick of the first valid index at or above rr_ptr
module uart_tx_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  g,
  output logic             any
);
  localparam logic [ID_W:0] N_L = (ID_W+1)'(N_REQ);
  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  off;
  logic [ID_W:0]    sum;
  always_comb begin
    rot = N_REQ'({req_valid, req_valid} >> rr_ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) off = rot[i] ? ID_W'(i) : off;
    sum = {1'b0, rr_ptr} + {1'b0, off};
    g   = sum >= N_L ? ID_W'(sum - N_L) : sum[ID_W-1:0];
    any = |req_valid;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter among N_REQ byte sources
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int ID_W         = 2,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_in,
  output logic               tx_en,
  input  logic               tx_busy,
  output logic [ID_W-1:0]    grant_id,
  output logic               active,
  output logic               err
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(BUSY_TIMEOUT - 1);
  localparam logic [ID_W-1:0] LAST    = ID_W'(N_REQ - 1);
  state_t           state_q, state_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic [7:0]       tx_in_q, tx_in_d;
  logic             tx_en_q, tx_en_d, active_q, active_d, err_q, err_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d, rr_q, rr_d, g;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             any, grant, timeout;
  uart_tx_arbiter_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req_valid(req_valid),
    .rr_ptr   (rr_q),
    .g        (g),
    .any      (any)
  );
  assign grant   = state_q == IDLE && !tx_busy && any;
  assign timeout = state_q == WAIT_BUSY && !tx_busy && cnt_q == CNT_MAX;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= '0;
      tx_in_q     <= '0;
      tx_en_q     <= 1'b0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
      grant_id_q  <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      tx_in_q     <= tx_in_d;
      tx_en_q     <= tx_en_d;
      active_q    <= active_d;
      err_q       <= err_d;
      grant_id_q  <= grant_id_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE      ? (grant ? START : IDLE) :
              state_q == START     ? WAIT_BUSY :
              state_q == WAIT_BUSY ? (tx_busy ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY) :
                                     (tx_busy ? WAIT_DONE : IDLE);
  end
  always_comb begin
    req_ready_d = grant ? N_REQ'(1) << g : '0;
    tx_in_d     = grant ? 8'(req_data >> {g, 3'b000}) : tx_in_q;
    grant_id_d  = grant ? g : grant_id_q;
    rr_d        = grant ? (g == LAST ? '0 : g + 1'b1) : rr_q;
    tx_en_d     = state_q == START;
    active_d    = state_d != IDLE;
    err_d       = timeout;
    cnt_d       = state_q == START ? '0 : state_q == WAIT_BUSY ? cnt_q + 1'b1 : cnt_q;
  end
  assign req_ready = req_ready_q;
  assign tx_in     = tx_in_q;
  assign tx_en     = tx_en_q;
  assign active    = active_q;
  assign err       = err_q;
  assign grant_id  = grant_id_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for the round-robin UART transmit arbiter
module tb_uart_tx_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_in;
  logic        tx_en;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err;
  int checks = 0;
  int errors = 0;
  uart_tx_arbiter #(.N_REQ(4), .ID_W(2), .BUSY_TIMEOUT(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx_in    (tx_in),
    .tx_en    (tx_en),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .active   (active),
    .err      (err)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_txen"}, 32'(tx_en), 32'h0);
    chk({tag, "_active"}, 32'(active), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_gid"}, 32'(grant_id), 32'h0);
    chk({tag, "_txin"}, 32'(tx_in), 32'h0);
  endtask
  task automatic serve(input logic [1:0] g, input logic [7:0] d, input bit drop);
    logic [31:0] saved;
    step();
    chk("grant_ready", 32'(req_ready), 32'(1) << g);
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("grant_txin", 32'(tx_in), 32'(d));
    chk("grant_active", 32'(active), 32'h1);
    chk("grant_txen", 32'(tx_en), 32'h0);
    if (drop) req_valid[g] = 1'b0;
    saved = req_data;
    req_data = ~req_data;
    step();
    chk("start_txen", 32'(tx_en), 32'h1);
    chk("start_ready", 32'(req_ready), 32'h0);
    tx_busy = 1'b1;
    step();
    chk("busy_txen", 32'(tx_en), 32'h0);
    chk("busy_active", 32'(active), 32'h1);
    repeat (3) step();
    chk("frame_active", 32'(active), 32'h1);
    chk("frame_txin", 32'(tx_in), 32'(d));
    chk("frame_ready", 32'(req_ready), 32'h0);
    tx_busy = 1'b0;
    step();
    chk("done_active", 32'(active), 32'h0);
    chk("done_txin", 32'(tx_in), 32'(d));
    chk("done_gid", 32'(grant_id), 32'(g));
    chk("done_err", 32'(err), 32'h0);
    req_data = saved;
  endtask
  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    tx_busy = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    reset = 1'b0;
    req_data = 32'h00A5_0000;
    req_valid = 4'b0100;
    serve(2'd2, 8'hA5, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_data = 32'h4332_2110;
    req_valid = 4'b1011;
    serve(2'd0, 8'h10, 1'b1);
    serve(2'd1, 8'h21, 1'b1);
    serve(2'd3, 8'h43, 1'b1);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      case (k % 4)
        0: serve(2'd0, 8'h10, 1'b0);
        1: serve(2'd1, 8'h21, 1'b0);
        2: serve(2'd2, 8'h32, 1'b0);
        default: serve(2'd3, 8'h43, 1'b0);
      endcase
    end
    req_valid = 4'b0001;
    step();
    chk("to_grant_ready", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    step();
    chk("to_txen", 32'(tx_en), 32'h1);
    for (int k = 1; k < 8; k++) begin
      step();
      chk("to_wait_err", 32'(err), 32'h0);
      chk("to_wait_active", 32'(active), 32'h1);
    end
    step();
    chk("to_err", 32'(err), 32'h1);
    chk("to_active", 32'(active), 32'h0);
    step();
    chk("to_err_clear", 32'(err), 32'h0);
    req_valid = 4'b0010;
    serve(2'd1, 8'h21, 1'b1);
    req_valid = 4'b1000;
    step();
    chk("rst_grant_ready", 32'(req_ready), 32'h8);
    req_valid = 4'b0000;
    step();
    tx_busy = 1'b1;
    step();
    step();
    chk("rst_pre_active", 32'(active), 32'h1);
    reset = 1'b1;
    step();
    chk_reset_outputs("midframe_reset");
    reset = 1'b0;
    req_valid = 4'b0101;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("rst_hold", {28'h0, req_ready | {3'b000, tx_en}}, 32'h0);
    end
    chk("rst_hold_active", 32'(active), 32'h0);
    tx_busy = 1'b0;
    serve(2'd0, 8'h10, 1'b1);
    serve(2'd2, 8'h32, 1'b1);
    step();
    chk("final_idle_ready", 32'(req_ready), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
